eth_reply_tx: RTL
=================

Name: eth_reply_tx

Overview:
Transmit-side companion to the Ethernet receive parser. It builds ARP replies and ICMP echo replies from the parser's pending-request flags, captured addresses and buffered ping payload. It streams each reply as 32-bit words on a sop/eop/vld/rdy interface toward the MAC TX FIFO. It clears each request flag once the matching reply frame has been fully accepted.

Parameters:
IP_TTL, 8'd64, TTL placed in the generated IPv4 header
IP_ID, 16'h0000, IPv4 identification field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_self_ip  in  32  own IPv4 address
i_self_mac  in  48  own MAC address
i_arp_req_flag  in  1  ARP request pending
i_arp_req_mac  in  48  requester MAC
i_arp_req_ip  in  32  requester IP
o_clear_arp_req  out  1  one-cycle pulse, ARP request serviced
i_ping_req_flag  in  1  echo request pending
i_ping_req_mac  in  48  requester MAC
i_ping_req_ip  in  32  requester IP
i_ping_data  in  32  show-ahead ICMP message word (type/code/crc word first)
i_payload_size  in  8  ICMP message length in 32-bit words (N)
o_ping_rdy  out  1  pops i_ping_data
o_clear_ping_req  out  1  one-cycle pulse, ping request serviced
o_out_data  out  32  frame word
o_out_sop  out  1  first word of frame
o_out_eop  out  1  last word of frame
o_out_vld  out  1  word valid
i_out_rdy  in  1  sink accepts word

Behaviour:
- Reset (async, rst_n=0): state IDLE. o_out_vld, o_out_sop, o_out_eop, o_ping_rdy, o_clear_arp_req and o_clear_ping_req are 0. o_out_data is 0.
- Reset mid-frame aborts the frame. No eop is emitted and no flag is cleared, so the request is serviced again after reset.
- Handshake: a word transfers when o_out_vld && i_out_rdy. While o_out_vld && !i_out_rdy, data/sop/eop are held stable. o_out_vld is never dropped mid-frame.
- Frame word layout matches the receive side: word0 = {16'h0000, dst_mac[47:32]}, word1 = dst_mac[31:0], word2 = self_mac[47:16], word3 = {self_mac[15:0], ethertype}.
- States: IDLE -> SEL -> CSUM -> HDR -> PAYLOAD -> DONE -> IDLE. ARP frames skip CSUM and PAYLOAD.
- IDLE: if i_arp_req_flag is set, select ARP; else if i_ping_req_flag is set, select PING. ARP wins when both are set. Selection, MAC, IP and N are latched on leaving IDLE and held for the whole frame.
- PING with N<2: no frame is sent. o_clear_ping_req pulses and the FSM returns to IDLE.
- ARP frame: 11 words, eop on word10.
  - word3 low half = 16'h0806
  - word4 = 32'h00010800
  - word5 = 32'h06040002
  - word6 = self_mac[47:16]
  - word7 = {self_mac[15:0], self_ip[31:16]}
  - word8 = {self_ip[15:0], req_mac[47:32]}
  - word9 = req_mac[31:0]
  - word10 = req_ip
- PING frame: 9 header words, then N payload words. Total 9+N words, eop on the last payload word.
  - word3 low half = 16'h0800
  - word4 = {16'h4500, total_len}, with total_len = 20 + 4*N computed in 16 bits
  - word5 = {IP_ID, 16'h4000}
  - word6 = {IP_TTL, 8'h01, ip_csum}
  - word7 = self_ip
  - word8 = req_ip
- CSUM (up to 4 cycles): ip_csum = ~(ones'-complement 16-bit sum of all ten IPv4 header halfwords, with the csum field = 0). Carries are end-around folded until there is no carry.
- PAYLOAD:
  - o_ping_rdy = o_out_vld && i_out_rdy, combinational, during PAYLOAD only. Exactly N pops per frame.
  - First payload word is transformed to {8'h00, code, crc'}, with crc' = crc + 16'h0800 as a ones'-complement add (carry folded).
  - All other payload words pass through unchanged.
- DONE: the matching clear pulse is asserted for exactly 1 cycle, on the cycle after the eop transfer. IDLE then re-samples flags, so there is no new frame while the flag is still set in that cycle.
- Back-to-back: minimum one idle cycle between frames (eop -> next sop).

Test Plan:
- ARP reply: self_mac=02:00:00:00:00:01, self_ip=C0A8010A, req AABBCCDDEEFF/C0A80101, rdy=1 -> 11 words; word0=0000AABB, word5=06040002, word8=010AAABB, word10=C0A80101; sop on w0, eop on w10; clear_arp pulse 1 cycle later.
- Ping reply, N=10, first payload word 08001234 -> 19 words; word4=4500003C; word6 high half=4001; first payload word=00001A34; exactly 10 o_ping_rdy pulses; ip_csum matches reference ones'-complement model.
- Checksum wrap: first payload word 0800F8FF -> 00000100.
- Backpressure: random i_out_rdy (~50%) during ping N=4 -> data/sop/eop held while stalled; o_ping_rdy only on transfer cycles; output identical to the rdy=1 run.
- Both flags set in the same cycle -> ARP frame first, then ping frame; each clear pulse is issued once.
- rst_n low mid-ping at word 12 -> outputs 0 immediately, no clear pulse; after release, the ping frame restarts from word0. N=1 -> no frame, clear_ping pulses.

Source files
------------

// File: rtl/eth_reply_tx.sv
// ARP / ICMP echo reply generator: builds reply frames from the receive parser's
// pending requests and streams them as 32-bit sop/eop/vld/rdy words.
module eth_reply_tx #(
    parameter logic [7:0]  IP_TTL = 8'd64,
    parameter logic [15:0] IP_ID  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_self_ip,
    input  logic [47:0] i_self_mac,
    input  logic        i_arp_req_flag,
    input  logic [47:0] i_arp_req_mac,
    input  logic [31:0] i_arp_req_ip,
    output logic        o_clear_arp_req,
    input  logic        i_ping_req_flag,
    input  logic [47:0] i_ping_req_mac,
    input  logic [31:0] i_ping_req_ip,
    input  logic [31:0] i_ping_data,
    input  logic [7:0]  i_payload_size,
    output logic        o_ping_rdy,
    output logic        o_clear_ping_req,
    output logic [31:0] o_out_data,
    output logic        o_out_sop,
    output logic        o_out_eop,
    output logic        o_out_vld,
    input  logic        i_out_rdy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEL     = 3'd1;
    localparam logic [2:0] S_CSUM    = 3'd2;
    localparam logic [2:0] S_HDR     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]  state_reg;
    logic        is_arp_reg;
    logic [47:0] req_mac_reg;
    logic [31:0] req_ip_reg;
    logic [47:0] self_mac_reg;
    logic [31:0] self_ip_reg;
    logic [7:0]  n_reg;
    logic [3:0]  word_idx_reg;
    logic [7:0]  pay_cnt_reg;
    logic [1:0]  csum_cnt_reg;
    logic [19:0] csum_acc_reg;
    logic [15:0] ip_csum_reg;

    logic [15:0] total_len;
    logic [15:0] hdr_hw [10];
    logic [19:0] hdr_sum;
    logic [31:0] hdr_word;
    logic [16:0] crc_sum;
    logic [15:0] crc_fold;
    logic [31:0] pay_word;
    logic        vld;
    logic        xfer;

    assign total_len = 16'd20 + {6'd0, n_reg, 2'b00};

    // IPv4 header halfwords with the checksum field held at zero
    assign hdr_hw[0] = 16'h4500;
    assign hdr_hw[1] = total_len;
    assign hdr_hw[2] = IP_ID;
    assign hdr_hw[3] = 16'h4000;
    assign hdr_hw[4] = {IP_TTL, 8'h01};
    assign hdr_hw[5] = 16'h0000;
    assign hdr_hw[6] = self_ip_reg[31:16];
    assign hdr_hw[7] = self_ip_reg[15:0];
    assign hdr_hw[8] = req_ip_reg[31:16];
    assign hdr_hw[9] = req_ip_reg[15:0];

    always_comb begin
        hdr_sum = 20'd0;
        for (int i = 0; i < 10; i++) begin
            hdr_sum = hdr_sum + {4'd0, hdr_hw[i]};
        end
    end

    // Echo request -> reply: type becomes 0, so the ICMP checksum rises by 0x0800
    assign crc_sum  = {1'b0, i_ping_data[15:0]} + 17'h00800;
    assign crc_fold = crc_sum[15:0] + {15'd0, crc_sum[16]};
    assign pay_word = (pay_cnt_reg == 8'd0) ? {8'h00, i_ping_data[23:16], crc_fold}
                                            : i_ping_data;

    always_comb begin
        hdr_word = 32'h0;
        case (word_idx_reg)
            4'd0:  hdr_word = {16'h0000, req_mac_reg[47:32]};
            4'd1:  hdr_word = req_mac_reg[31:0];
            4'd2:  hdr_word = self_mac_reg[47:16];
            4'd3:  hdr_word = {self_mac_reg[15:0], (is_arp_reg ? 16'h0806 : 16'h0800)};
            4'd4:  hdr_word = is_arp_reg ? 32'h00010800 : {16'h4500, total_len};
            4'd5:  hdr_word = is_arp_reg ? 32'h06040002 : {IP_ID, 16'h4000};
            4'd6:  hdr_word = is_arp_reg ? self_mac_reg[47:16] : {IP_TTL, 8'h01, ip_csum_reg};
            4'd7:  hdr_word = is_arp_reg ? {self_mac_reg[15:0], self_ip_reg[31:16]} : self_ip_reg;
            4'd8:  hdr_word = is_arp_reg ? {self_ip_reg[15:0], req_mac_reg[47:32]} : req_ip_reg;
            4'd9:  hdr_word = req_mac_reg[31:0];
            4'd10: hdr_word = req_ip_reg;
            default: hdr_word = 32'h0;
        endcase
    end

    assign vld  = (state_reg == S_HDR) || (state_reg == S_PAYLOAD);
    assign xfer = vld && i_out_rdy;

    assign o_out_vld  = vld;
    assign o_out_sop  = (state_reg == S_HDR) && (word_idx_reg == 4'd0);
    assign o_out_eop  = ((state_reg == S_HDR) && is_arp_reg && (word_idx_reg == 4'd10)) ||
                        ((state_reg == S_PAYLOAD) && (pay_cnt_reg == n_reg - 8'd1));
    assign o_out_data = (state_reg == S_HDR)     ? hdr_word :
                        (state_reg == S_PAYLOAD) ? pay_word : 32'h0;
    assign o_ping_rdy       = (state_reg == S_PAYLOAD) && i_out_rdy;
    assign o_clear_arp_req  = (state_reg == S_DONE) && is_arp_reg;
    assign o_clear_ping_req = (state_reg == S_DONE) && !is_arp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            is_arp_reg   <= 1'b0;
            req_mac_reg  <= 48'h0;
            req_ip_reg   <= 32'h0;
            self_mac_reg <= 48'h0;
            self_ip_reg  <= 32'h0;
            n_reg        <= 8'h0;
            word_idx_reg <= 4'h0;
            pay_cnt_reg  <= 8'h0;
            csum_cnt_reg <= 2'h0;
            csum_acc_reg <= 20'h0;
            ip_csum_reg  <= 16'h0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    self_mac_reg <= i_self_mac;
                    self_ip_reg  <= i_self_ip;
                    if (i_arp_req_flag) begin
                        is_arp_reg  <= 1'b1;
                        req_mac_reg <= i_arp_req_mac;
                        req_ip_reg  <= i_arp_req_ip;
                        n_reg       <= 8'h0;
                        state_reg   <= S_SEL;
                    end else if (i_ping_req_flag) begin
                        is_arp_reg  <= 1'b0;
                        req_mac_reg <= i_ping_req_mac;
                        req_ip_reg  <= i_ping_req_ip;
                        n_reg       <= i_payload_size;
                        state_reg   <= S_SEL;
                    end
                end
                S_SEL: begin
                    word_idx_reg <= 4'h0;
                    pay_cnt_reg  <= 8'h0;
                    csum_cnt_reg <= 2'h0;
                    if (is_arp_reg)
                        state_reg <= S_HDR;
                    else if (n_reg < 8'd2)
                        state_reg <= S_DONE;
                    else
                        state_reg <= S_CSUM;
                end
                S_CSUM: begin
                    // Sum, fold twice (enough for ten halfwords), then invert
                    csum_cnt_reg <= csum_cnt_reg + 2'd1;
                    case (csum_cnt_reg)
                        2'd0: csum_acc_reg <= hdr_sum;
                        2'd1, 2'd2: csum_acc_reg <= {4'd0, csum_acc_reg[15:0]} +
                                                    {16'd0, csum_acc_reg[19:16]};
                        default: begin
                            ip_csum_reg <= ~csum_acc_reg[15:0];
                            state_reg   <= S_HDR;
                        end
                    endcase
                end
                S_HDR: begin
                    if (xfer) begin
                        if (is_arp_reg && (word_idx_reg == 4'd10))
                            state_reg <= S_DONE;
                        else if (!is_arp_reg && (word_idx_reg == 4'd8))
                            state_reg <= S_PAYLOAD;
                        else
                            word_idx_reg <= word_idx_reg + 4'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (xfer) begin
                        if (pay_cnt_reg == n_reg - 8'd1)
                            state_reg <= S_DONE;
                        else
                            pay_cnt_reg <= pay_cnt_reg + 8'd1;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule
